// File: rtl/lvds_bank_en_seq.sv
// LVDS output-enable sequencer for one I/O bank: settles the driver before
// reporting READY, and waits for serializer idle plus a guard period before disabling.
module lvds_bank_en_seq #(
  parameter int ON_SETTLE_CYC = 16,
  parameter int OFF_GUARD_CYC = 8,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_req,
  input  logic       tx_idle,
  output logic       lvdseni,
  output logic       ready,
  output logic       busy,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_SETTLE = 2'b01,
    ST_ON     = 2'b10,
    ST_GUARD  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(ON_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD  = CNT_W'(OFF_GUARD_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_OFF: begin
        if (en_req) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (!en_req) begin
          state_d = ST_GUARD;
          cnt_d   = GUARD_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ON: begin
        // Disable waits indefinitely for the serializer; READY stays high meanwhile.
        if (!en_req && tx_idle) begin
          state_d = ST_GUARD;
          cnt_d   = GUARD_LOAD;
        end
      end
      ST_GUARD: begin
        // Guard always runs to completion, so a re-request passes through OFF.
        if (cnt_q == '0) state_d = ST_OFF;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Outputs are registered by decoding the next state into flops.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      lvdseni <= 1'b0;
      ready   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvdseni <= (state_d != ST_OFF);
      ready   <= (state_d == ST_ON);
      busy    <= (state_d == ST_SETTLE) || (state_d == ST_GUARD);
    end
  end

  assign state = state_q;

endmodule
